// File: rtl/spi_slave_mclk.sv
// SPI mode-0 slave clocked entirely by mclk: oversamples sclk/cs/mosi, one-deep TX buffer, valid/ready RX.
// Define SPI_SLV_STATUS_EN to add sticky rx_overrun / tx_underrun flags with a status_clr input.
module spi_slave_mclk #(
  parameter int            DW    = 8,
  parameter logic [DW-1:0] DUMMY = '0
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          cs,
  input  logic          mosi,
  output logic          miso,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
`ifdef SPI_SLV_STATUS_EN
  input  logic          status_clr,
  output logic          rx_overrun,
  output logic          tx_underrun,
`endif
  input  logic          rx_ready
);

  localparam int             CW   = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sclk_sync_q, sclk_sync_d;
  logic [2:0]    cs_sync_q, cs_sync_d;
  logic [1:0]    mosi_sync_q, mosi_sync_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          miso_q, miso_d;
  logic [DW-1:0] txbuf_q, txbuf_d;
  logic          txfull_q, txfull_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          sclk_rise, sclk_fall, cs_fall, cs_rise;

  // Bit 2 of each sync chain is the previous synced value, used for edge detection.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[1:0], cs};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    txbuf_d     = txbuf_q;
    txfull_d    = txfull_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        if (txfull_q) begin
          shreg_d  = txbuf_q;
          miso_d   = txbuf_q[DW-1];
          txfull_d = 1'b0;
        end else begin
          shreg_d = DUMMY;
          miso_d  = DUMMY[DW-1];
        end
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[DW-2:0], mosi_sync_q[1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end else if (sclk_fall) begin
          miso_d = shreg_q[DW-1];
        end
      end
      DONE: begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
        state_d    = cs_sync_q[1] ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    // A word accepted during LOAD sees txfull_q=0, so it is held for the following frame.
    if (tx_valid && !txfull_q) begin
      txfull_d = 1'b1;
      txbuf_d  = tx_data;
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      txbuf_q     <= '0;
      txfull_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      txbuf_q     <= txbuf_d;
      txfull_q    <= txfull_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = ~txfull_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLV_STATUS_EN
  logic rx_overrun_q, rx_overrun_d;
  logic tx_underrun_q, tx_underrun_d;

  // Set events take priority over a simultaneous clear.
  always_comb begin
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    if (status_clr) begin
      rx_overrun_d  = 1'b0;
      tx_underrun_d = 1'b0;
    end
    if (state_q == DONE && rx_valid_q) rx_overrun_d = 1'b1;
    if (state_q == LOAD && !txfull_q) tx_underrun_d = 1'b1;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_mclk.sv
// Directed bench for spi_slave_mclk: plays an SPI mode-0 master with hand-computed expected words.
module tb_spi_slave_mclk;
  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
`ifdef SPI_SLV_STATUS_EN
  logic       status_clr = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] mi, mi2;

  spi_slave_mclk #(.DW(8), .DUMMY(8'h00)) dut (
    .mclk(mclk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLV_STATUS_EN
    .status_clr(status_clr), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
`endif
    .rx_ready(rx_ready)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    @(negedge mclk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge mclk);
    tx_valid = 1'b0;
  endtask

  // Master side: mosi changes while sclk is low, miso sampled at the sclk rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rcv);
    rcv = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      #40 sclk = 1'b1;
      rcv = {rcv[6:0], miso};
      #40 sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] rcv);
    cs = 1'b0;
    #80;
    xfer(mo, 8, rcv);
    #40 cs = 1'b1;
    #100;
  endtask

  task automatic consume();
    @(negedge mclk);
    rx_ready = 1'b1;
    @(negedge mclk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    #18;
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
`ifdef SPI_SLV_STATUS_EN
    check("rst_overrun", rx_overrun, 0);
    check("rst_underrun", tx_underrun, 0);
`endif
    reset = 1'b1;
    #40;

    // 1. basic duplex + 6. handshake hold
    push(8'hA5);
    check("t1_tx_ready_low", tx_ready, 0);
    frame(8'h3C, mi);
    check("t1_miso_word", mi, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_tx_ready_back", tx_ready, 1);
    check("t1_idle_miso", miso, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge mclk);
      check("t6_hold_data", rx_data, 8'h3C);
      check("t6_hold_valid", rx_valid, 1);
    end
    @(negedge mclk);
    rx_ready = 1'b1;
    #1 check("t6_valid_before_edge", rx_valid, 1);
    @(negedge mclk);
    check("t6_valid_fall", rx_valid, 0);
    rx_ready = 1'b0;

    // 2. no TX word -> DUMMY
    frame(8'hFF, mi);
    check("t2_miso_dummy", mi, 8'h00);
    check("t2_rx_data", rx_data, 8'hFF);
    check("t2_rx_valid", rx_valid, 1);
`ifdef SPI_SLV_STATUS_EN
    check("t2_underrun", tx_underrun, 1);
    @(negedge mclk);
    status_clr = 1'b1;
    @(negedge mclk);
    status_clr = 1'b0;
    check("t2_underrun_clr", tx_underrun, 0);
`endif
    consume();

    // 3. back-to-back frames, second word pushed after the first LOAD
    push(8'h11);
    cs = 1'b0;
    #80;
    push(8'h22);
    xfer(8'h5A, 8, mi);
    xfer(8'h7E, 8, mi2);
    #40 cs = 1'b1;
    #100;
    check("t3_miso_first", mi, 8'h11);
    check("t3_miso_second", mi2, 8'h22);
    check("t3_rx_data", rx_data, 8'h7E);
    check("t3_rx_valid", rx_valid, 1);
    check("t3_tx_ready", tx_ready, 1);
`ifdef SPI_SLV_STATUS_EN
    check("t3_overrun", rx_overrun, 1);
`endif
    consume();

    // 4. abort after 5 bits, then a full frame
    cs = 1'b0;
    #80;
    xfer(8'hF0, 5, mi);
    #40 cs = 1'b1;
    #100;
    check("t4_abort_valid", rx_valid, 0);
    check("t4_abort_data", rx_data, 8'h7E);
    frame(8'h96, mi);
    check("t4_rx_data", rx_data, 8'h96);
    check("t4_rx_valid", rx_valid, 1);
    check("t4_miso_dummy", mi, 8'h00);
    consume();

    // 5. reset mid-frame with a word held in the TX buffer
    cs = 1'b0;
    #80;
    push(8'hE7);
    check("t5_tx_ready_full", tx_ready, 0);
    xfer(8'hAA, 3, mi);
    reset = 1'b0;
    #2;
    check("t5_rst_miso", miso, 0);
    check("t5_rst_tx_ready", tx_ready, 1);
    check("t5_rst_rx_data", rx_data, 0);
    check("t5_rst_rx_valid", rx_valid, 0);
    #18 cs = 1'b1;
    #20 reset = 1'b1;
    #60;
    frame(8'hC3, mi);
    check("t5_rx_data", rx_data, 8'hC3);
    check("t5_rx_valid", rx_valid, 1);
    check("t5_miso_dummy", mi, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
